// File: rtl/rs_pkg.sv
// Shared encodings and reset sentinels for the reservation station bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rs_pkg;

    // Per-entry lifecycle: FREE -> WAIT/READY -> EXEC -> FREE (stores skip EXEC).
    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2,
        RS_EXEC  = 2'd3
    } rs_state_t;

    // Field values held by an entry that has never been written since reset/flush.
    localparam logic [15:0] VJ_VK_NO_VALUE = 16'hFFF0;
    localparam int          Q_NO_TAG       = 0;
    localparam logic [6:0]  A_NO_VALUE     = 7'h78;

    // Opcode that produces no register result (store).
    localparam logic [2:0]  NOWB_OP_DEFAULT = 3'd5;

endpackage

// File: rtl/rs_select.sv
// Entry picker: one-hot grant + index over a request vector; optional age matrix.
// Latency: combinational grant from req; age matrix updates at the alloc edge.
// Backpressure: none; grant is purely a function of req and recorded age.
//
// Ports: clk/rst_n, clr (sync clear of age), alloc (one-hot entry allocated this
// edge), req (candidate vector), grant (one-hot), idx (binary grant index).
// With RES_STATION_OLDEST_FIRST_EN defined and AGE_EN=1 the oldest requester wins,
// otherwise the lowest index wins.
module rs_select #(
    parameter int N      = 4,
    parameter bit AGE_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [N-1:0]         alloc,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [N-1:0] pri_grant;
    logic         found;

    always_comb begin
        pri_grant = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                pri_grant[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

`ifdef RES_STATION_OLDEST_FIRST_EN
    generate
        if (AGE_EN) begin : g_age
            // age[i][j] = 1 means entry i was allocated before entry j.
            logic [N-1:0] age [N];
            logic [N-1:0] age_grant;
            logic         blocked;
            wire          unused_pri = ^pri_grant;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) age[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < N; i++) age[i] <= '0;
                end else begin
                    // New entry is younger than everything currently present.
                    for (int k = 0; k < N; k++) begin
                        if (alloc[k]) begin
                            for (int i = 0; i < N; i++) begin
                                age[k][i] <= 1'b0;
                                if (i != k) age[i][k] <= 1'b1;
                            end
                        end
                    end
                end
            end

            always_comb begin
                age_grant = '0;
                blocked   = 1'b0;
                for (int i = 0; i < N; i++) begin
                    blocked = 1'b0;
                    for (int j = 0; j < N; j++) begin
                        if (req[j] && age[j][i]) blocked = 1'b1;
                    end
                    age_grant[i] = req[i] && !blocked;
                end
            end

            assign grant = age_grant;
        end else begin : g_pri
            wire unused_ok = &{1'b0, clk, rst_n, clr, alloc};
            assign grant = pri_grant;
        end
    endgenerate
`else
    wire unused_ok = &{1'b0, clk, rst_n, clr, alloc, AGE_EN};
    assign grant = pri_grant;
`endif

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/res_station_bank.sv
// Multi-entry Tomasulo reservation station: issue, CDB operand snoop, dispatch, completion.
// Latency: issue->dispatch >= 1 cycle; CDB wakeup->dispatch >= 1 cycle; store frees on dispatch.
// Backpressure: issue_ready low when no FREE entry; entries hold in READY while disp_ready is low.
//
// Ports: issue_* (request, lowest FREE entry tag in issue_tag), cdb_* (result broadcast),
// disp_* (presented READY entry, valid/ready handshake), busy_vec (per-entry not FREE),
// flush (sync clear). Build option RES_STATION_OLDEST_FIRST_EN selects oldest-READY dispatch.
module res_station_bank
    import rs_pkg::*;
#(
    parameter int              ENTRIES  = 4,
    parameter int              DATA_W   = 16,
    parameter int              TAG_W    = 3,
    parameter int              TAG_BASE = 1,
    parameter int              IMM_W    = 7,
    parameter int              OP_W     = 3,
    parameter logic [OP_W-1:0] NOWB_OP  = OP_W'(NOWB_OP_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               issue_valid,
    output logic               issue_ready,
    output logic [TAG_W-1:0]   issue_tag,
    input  logic [OP_W-1:0]    issue_op,
    input  logic [DATA_W-1:0]  issue_vj,
    input  logic [DATA_W-1:0]  issue_vk,
    input  logic [TAG_W-1:0]   issue_qj,
    input  logic [TAG_W-1:0]   issue_qk,
    input  logic [IMM_W-1:0]   issue_a,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_value,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic [OP_W-1:0]    disp_op,
    output logic [DATA_W-1:0]  disp_vj,
    output logic [DATA_W-1:0]  disp_vk,
    output logic [IMM_W-1:0]   disp_a,
    output logic [TAG_W-1:0]   disp_tag,
    output logic [ENTRIES-1:0] busy_vec
);
    localparam int IW = $clog2(ENTRIES);

    rs_state_t         st [ENTRIES];
    logic [DATA_W-1:0] vj [ENTRIES];
    logic [DATA_W-1:0] vk [ENTRIES];
    logic [TAG_W-1:0]  qj [ENTRIES];
    logic [TAG_W-1:0]  qk [ENTRIES];
    logic [IMM_W-1:0]  a  [ENTRIES];
    logic [OP_W-1:0]   op [ENTRIES];

    logic [ENTRIES-1:0] free_vec, ready_vec, free_grant, disp_grant, alloc_vec;
    logic [ENTRIES-1:0] hit_j, hit_k, done;
    logic [IW-1:0]      free_idx, disp_idx;
    logic               issue_fire, disp_fire, cdb_live, byp_j, byp_k;
    logic [TAG_W-1:0]   new_qj, new_qk;

    assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(Q_NO_TAG));

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        hit_j     = '0;
        hit_k     = '0;
        done      = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i]  = (st[i] == RS_FREE);
            ready_vec[i] = (st[i] == RS_READY);
            hit_j[i]     = cdb_live && (cdb_tag == qj[i]);
            hit_k[i]     = cdb_live && (cdb_tag == qk[i]);
            done[i]      = cdb_valid && (cdb_tag == TAG_W'(TAG_BASE + i));
        end
    end

    // Free picker: always lowest index, so issue_tag is predictable.
    rs_select #(.N(ENTRIES), .AGE_EN(1'b0)) u_free_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .alloc ('0),
        .req   (free_vec),
        .grant (free_grant),
        .idx   (free_idx)
    );

    rs_select #(.N(ENTRIES), .AGE_EN(1'b1)) u_disp_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .alloc (alloc_vec),
        .req   (ready_vec),
        .grant (disp_grant),
        .idx   (disp_idx)
    );

    // Everything below is driven from registered state only, so a completion in this
    // cycle cannot be reused by a same-cycle issue, and disp_valid ignores disp_ready.
    assign issue_ready = |free_vec;
    assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign issue_fire  = issue_valid && issue_ready;
    assign alloc_vec   = issue_fire ? free_grant : '0;
    assign busy_vec    = ~free_vec;

    assign disp_valid = |ready_vec;
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_op    = op[disp_idx];
    assign disp_vj    = vj[disp_idx];
    assign disp_vk    = vk[disp_idx];
    assign disp_a     = a[disp_idx];
    assign disp_tag   = TAG_W'(TAG_BASE) + TAG_W'(disp_idx);

    // Result on the CDB in the issue cycle is captured directly into the new entry.
    assign byp_j  = cdb_live && (cdb_tag == issue_qj);
    assign byp_k  = cdb_live && (cdb_tag == issue_qk);
    assign new_qj = byp_j ? TAG_W'(Q_NO_TAG) : issue_qj;
    assign new_qk = byp_k ? TAG_W'(Q_NO_TAG) : issue_qk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                st[i] <= RS_FREE;
                vj[i] <= DATA_W'(VJ_VK_NO_VALUE);
                vk[i] <= DATA_W'(VJ_VK_NO_VALUE);
                qj[i] <= TAG_W'(Q_NO_TAG);
                qk[i] <= TAG_W'(Q_NO_TAG);
                a[i]  <= IMM_W'(A_NO_VALUE);
                op[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (flush) begin
                    st[i] <= RS_FREE;
                    vj[i] <= DATA_W'(VJ_VK_NO_VALUE);
                    vk[i] <= DATA_W'(VJ_VK_NO_VALUE);
                    qj[i] <= TAG_W'(Q_NO_TAG);
                    qk[i] <= TAG_W'(Q_NO_TAG);
                    a[i]  <= IMM_W'(A_NO_VALUE);
                    op[i] <= '0;
                end else begin
                    unique case (st[i])
                        RS_FREE: if (alloc_vec[i]) begin
                            op[i] <= issue_op;
                            a[i]  <= issue_a;
                            vj[i] <= byp_j ? cdb_value : issue_vj;
                            vk[i] <= byp_k ? cdb_value : issue_vk;
                            qj[i] <= new_qj;
                            qk[i] <= new_qk;
                            st[i] <= ((new_qj != '0) || (new_qk != '0)) ? RS_WAIT : RS_READY;
                        end
                        RS_WAIT: begin
                            if (hit_j[i]) begin
                                vj[i] <= cdb_value;
                                qj[i] <= TAG_W'(Q_NO_TAG);
                            end
                            if (hit_k[i]) begin
                                vk[i] <= cdb_value;
                                qk[i] <= TAG_W'(Q_NO_TAG);
                            end
                            if ((hit_j[i] || qj[i] == '0) && (hit_k[i] || qk[i] == '0))
                                st[i] <= RS_READY;
                        end
                        RS_READY: if (disp_fire && disp_grant[i]) begin
                            st[i] <= (op[i] == NOWB_OP) ? RS_FREE : RS_EXEC;
                        end
                        RS_EXEC: if (done[i]) st[i] <= RS_FREE;
                        default: st[i] <= RS_FREE;
                    endcase
                end
            end
        end
    end

endmodule
